aqp_esp_uart_tx: RTL and testbench



---
 rtl/aqp_esp_uart_tx_pkg.sv | 29 ++
 rtl/aqp_esp_uart_tx_sync2.sv | 29 ++
 rtl/aqp_esp_uart_tx.sv | 127 ++++++++++++
 tb/tb_aqp_esp_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aqp_esp_uart_tx_pkg.sv
// Shared definitions for the ESP UART transmitter.
//   tx_state_e     : transmitter FSM states
//   FLAG_CHAR_DEF  : default frame delimiter byte
//   ESC_CHAR_DEF   : default escape byte
//   ESC_XOR        : value XORed into an escaped byte
//   needs_escape() : true when a data byte collides with a control byte
package aqp_esp_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAITCTS
  } tx_state_e;

  localparam logic [7:0] FLAG_CHAR_DEF = 8'h7E;
  localparam logic [7:0] ESC_CHAR_DEF  = 8'h7D;
  localparam logic [7:0] ESC_XOR       = 8'h20;

  function automatic logic needs_escape(input logic [7:0] b,
                                        input logic [7:0] flag_char,
                                        input logic [7:0] esc_char);
    return (b == flag_char) || (b == esc_char);
  endfunction

endpackage

// File: rtl/aqp_esp_uart_tx_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   reset : asynchronous, active-high; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module aqp_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aqp_esp_uart_tx.sv
// 8N1 UART transmitter fed by the ESP UART TX FIFO, with byte stuffing.
//   clk, reset   : system clock; asynchronous active-high reset
//   fifo_rddata  : 9-bit FIFO word, valid the cycle after fifo_rd_en;
//                  bit 8 set = raw framing byte, never stuffed
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : single-cycle pop strobe, only issued from IDLE
//   uart_cts_n   : ESP clear-to-send, active-low, asynchronous
//   uart_txd     : serial output, LSB first, idle high
//   busy         : high whenever the FSM is not in IDLE
module aqp_esp_uart_tx
  import aqp_esp_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 16,
  parameter logic [7:0]  ESC_CHAR  = ESC_CHAR_DEF,
  parameter logic [7:0]  FLAG_CHAR = FLAG_CHAR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] fifo_rddata,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       uart_cts_n,
  output logic       uart_txd,
  output logic       busy
);

  localparam int unsigned     CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_e        state_q, state_d;
  logic             cts_sync;
  logic             cts_ok;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_done;
  logic             in_frame;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_byte;
  logic [7:0]       pending_byte;
  logic             pending;

  // CTS resets to "not clear" so nothing is popped until the ESP is seen ready.
  aqp_sync2 #(.RST_VAL(1'b1)) u_cts_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_cts_n),
    .q     (cts_sync)
  );

  assign cts_ok    = !cts_sync;
  assign baud_done = (baud_cnt == '0);
  assign in_frame  = (state_q inside {ST_START, ST_DATA, ST_STOP});
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    uart_txd   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        // CTS is only consulted here and in WAITCTS: a started byte always finishes.
        if (!fifo_empty && cts_ok) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_START;
      ST_START: begin
        uart_txd = 1'b0;
        if (baud_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        uart_txd = shift_byte[bit_idx];
        if (baud_done && (bit_idx == 3'd7)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_done) state_d = pending ? ST_WAITCTS : ST_IDLE;
      end
      ST_WAITCTS: begin
        if (cts_ok) state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Baud timer, bit index and byte registers. The counter sits at BAUD_LAST
  // outside a frame so every bit, including the start bit, lasts BAUD_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt     <= BAUD_LAST;
      bit_idx      <= 3'd0;
      shift_byte   <= 8'h00;
      pending_byte <= 8'h00;
      pending      <= 1'b0;
    end else begin
      if (in_frame && !baud_done) baud_cnt <= baud_cnt - CNT_W'(1);
      else                        baud_cnt <= BAUD_LAST;

      // Wraps 7 -> 0 on the last data bit, ready for the next byte.
      if ((state_q == ST_DATA) && baud_done) bit_idx <= bit_idx + 3'd1;

      if (state_q == ST_LATCH) begin
        if (!fifo_rddata[8] && needs_escape(fifo_rddata[7:0], FLAG_CHAR, ESC_CHAR)) begin
          shift_byte   <= ESC_CHAR;
          pending_byte <= fifo_rddata[7:0] ^ ESC_XOR;
          pending      <= 1'b1;
        end else begin
          shift_byte <= fifo_rddata[7:0];
          pending    <= 1'b0;
        end
      end

      if ((state_q == ST_WAITCTS) && cts_ok) begin
        shift_byte <= pending_byte;
        pending    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aqp_esp_uart_tx.sv
// Directed self-checking bench for aqp_esp_uart_tx at BAUD_DIV=4.
// A small FIFO model feeds the DUT; a UART receiver model decodes uart_txd.
module tb_aqp_esp_uart_tx;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] fifo_rddata = 9'h000;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       uart_cts_n;
  logic       uart_txd;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model: words written by the stimulus, popped on fifo_rd_en.
  logic [8:0] fifo_mem [16];
  int head = 0;
  int tail = 0;
  int cyc  = 0;
  int rd_viol = 0;
  int rd_cyc[$];

  // Receiver model results.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         framing_err = 0;
  logic       mon_prev = 1'b1;
  logic       mon_abort;
  logic       mon_stop;
  logic [7:0] mon_byte;
  int         mon_s;

  assign fifo_empty = (head == tail);

  aqp_esp_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_rddata (fifo_rddata),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .uart_cts_n  (uart_cts_n),
    .uart_txd    (uart_txd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (fifo_empty || busy) rd_viol <= rd_viol + 1;
      rd_cyc.push_back(cyc);
      if (!fifo_empty) begin
        fifo_rddata <= fifo_mem[head % 16];
        head        <= head + 1;
      end
    end
  end

  // Mid-bit sampling receiver: start bit first seen at k=0, bit i at 5+4i, stop at 37.
  always begin
    @(negedge clk);
    if (!reset && mon_prev && !uart_txd) begin
      mon_s     = cyc;
      mon_abort = 1'b0;
      mon_byte  = 8'h00;
      mon_stop  = 1'b0;
      for (int k = 1; k <= 37; k++) begin
        @(negedge clk);
        if (reset) mon_abort = 1'b1;
        if ((k >= 5) && (k <= 33) && (((k - 5) % 4) == 0)) mon_byte[(k - 5) / 4] = uart_txd;
        if (k == 37) mon_stop = uart_txd;
      end
      if (!mon_abort) begin
        rx_q.push_back(mon_byte);
        rx_start.push_back(mon_s);
        if (!mon_stop) framing_err++;
      end
    end
    mon_prev = uart_txd;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    fifo_mem[tail % 16] = w;
    tail = tail + 1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((busy || !fifo_empty) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n >= 1000), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, r, n, bad, bad_busy, rb, xb;
    logic [39:0] cap;
    logic [39:0] exp_cap;
    logic [9:0]  fr;

    // Reset and idle.
    reset      = 1'b1;
    uart_cts_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(uart_txd), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((uart_txd !== 1'b1) || (busy !== 1'b0) || (fifo_rd_en !== 1'b0)) bad++;
    end
    check("idle_100_cycles_bad", 64'(bad), 64'd0);

    // Single plain byte 0x41: exact waveform and latency.
    rb = rd_cyc.size();
    xb = rx_q.size();
    @(negedge clk);
    push(9'h041);
    p = cyc;
    @(negedge clk);
    check("fetch_busy", 64'(busy), 64'd1);
    check("fetch_txd", 64'(uart_txd), 64'd1);
    repeat (2) @(negedge clk);
    fr = {1'b1, 8'h41, 1'b0};
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      cap[j]     = uart_txd;
      exp_cap[j] = fr[j / BD];
    end
    check("frame_41_waveform", 64'(cap), 64'(exp_cap));
    check("stop_last_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("after_stop_busy", 64'(busy), 64'd0);
    wait_idle("b41");
    check("b41_rd_pulses", 64'(rd_cyc.size() - rb), 64'd1);
    check("b41_rd_cycle", 64'(rd_cyc.size() > rb ? rd_cyc[rb] : -1), 64'(p));
    check("b41_rx_count", 64'(rx_q.size() - xb), 64'd1);
    if (rx_q.size() > xb) begin
      check("b41_rx_byte", 64'(rx_q[xb]), 64'h41);
      check("b41_start_latency", 64'(rx_start[xb] - p), 64'd3);
    end

    // Stuffing: 0x7E data -> 7D 5E with one WAITCTS cycle between frames.
    xb = rx_q.size();
    push(9'h07E);
    wait_idle("b7e");
    check("b7e_rx_count", 64'(rx_q.size() - xb), 64'd2);
    if (rx_q.size() >= xb + 2) begin
      check("b7e_byte0", 64'(rx_q[xb]), 64'h7D);
      check("b7e_byte1", 64'(rx_q[xb + 1]), 64'h5E);
      check("b7e_start_gap", 64'(rx_start[xb + 1] - rx_start[xb]), 64'd41);
    end

    // Raw framing byte is never stuffed.
    xb = rx_q.size();
    push(9'h17E);
    wait_idle("raw7e");
    check("raw7e_rx_count", 64'(rx_q.size() - xb), 64'd1);
    if (rx_q.size() > xb) check("raw7e_byte", 64'(rx_q[xb]), 64'h7E);

    // Escape byte as data -> 7D 5D.
    xb = rx_q.size();
    push(9'h07D);
    wait_idle("b7d");
    check("b7d_rx_count", 64'(rx_q.size() - xb), 64'd2);
    if (rx_q.size() >= xb + 2) begin
      check("b7d_byte0", 64'(rx_q[xb]), 64'h7D);
      check("b7d_byte1", 64'(rx_q[xb + 1]), 64'h5D);
    end

    // CTS blocks a pop while deasserted.
    uart_cts_n = 1'b1;
    repeat (4) @(negedge clk);
    rb = rd_cyc.size();
    xb = rx_q.size();
    push(9'h055);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((uart_txd !== 1'b1) || (busy !== 1'b0)) bad++;
    end
    check("cts_block_rd_pulses", 64'(rd_cyc.size() - rb), 64'd0);
    check("cts_block_line_bad", 64'(bad), 64'd0);
    uart_cts_n = 1'b0;
    r = cyc;
    n = 0;
    while ((rd_cyc.size() == rb) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    check("cts_release_pop", 64'(rd_cyc.size() - rb), 64'd1);
    if (rd_cyc.size() > rb) check("cts_release_within_3", 64'((rd_cyc[rb] - r) <= 3), 64'd1);
    wait_idle("cts55");
    if (rx_q.size() > xb) check("cts55_byte", 64'(rx_q[xb]), 64'h55);

    // CTS dropped mid-byte: first byte finishes, pending byte waits for CTS.
    xb = rx_q.size();
    push(9'h07D);
    p = cyc;
    repeat (10) @(negedge clk);
    uart_cts_n = 1'b1;
    repeat (40) @(negedge clk);
    bad      = 0;
    bad_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) bad++;
      if (busy !== 1'b1) bad_busy++;
    end
    check("waitcts_txd_bad", 64'(bad), 64'd0);
    check("waitcts_busy_bad", 64'(bad_busy), 64'd0);
    check("waitcts_rx_count", 64'(rx_q.size() - xb), 64'd1);
    if (rx_q.size() > xb) check("waitcts_byte0", 64'(rx_q[xb]), 64'h7D);
    uart_cts_n = 1'b0;
    wait_idle("waitcts");
    check("waitcts_total", 64'(rx_q.size() - xb), 64'd2);
    if (rx_q.size() >= xb + 2) check("waitcts_byte1", 64'(rx_q[xb + 1]), 64'h5D);

    // Three queued words: pops 43 cycles apart, bytes in order.
    rb = rd_cyc.size();
    xb = rx_q.size();
    push(9'h011);
    push(9'h022);
    push(9'h033);
    wait_idle("q3");
    check("q3_rd_pulses", 64'(rd_cyc.size() - rb), 64'd3);
    check("q3_rx_count", 64'(rx_q.size() - xb), 64'd3);
    if (rd_cyc.size() >= rb + 3) begin
      check("q3_gap0", 64'(rd_cyc[rb + 1] - rd_cyc[rb]), 64'd43);
      check("q3_gap1", 64'(rd_cyc[rb + 2] - rd_cyc[rb + 1]), 64'd43);
    end
    if (rx_q.size() >= xb + 3) begin
      check("q3_byte0", 64'(rx_q[xb]), 64'h11);
      check("q3_byte1", 64'(rx_q[xb + 1]), 64'h22);
      check("q3_byte2", 64'(rx_q[xb + 2]), 64'h33);
    end

    // Reset in the middle of the escaped first byte of 0x7E (data bit 1 is 0).
    rb = rd_cyc.size();
    xb = rx_q.size();
    push(9'h07E);
    repeat (12) @(negedge clk);
    check("pre_reset_txd_low", 64'(uart_txd), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("reset_midbyte_txd", 64'(uart_txd), 64'd1);
    check("reset_midbyte_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("post_reset_no_rx", 64'(rx_q.size() - xb), 64'd0);
    check("post_reset_idle", 64'(busy), 64'd0);
    check("post_reset_rd_pulses", 64'(rd_cyc.size() - rb), 64'd1);
    xb = rx_q.size();
    push(9'h041);
    wait_idle("post_reset");
    check("post_reset_rx_count", 64'(rx_q.size() - xb), 64'd1);
    if (rx_q.size() > xb) check("post_reset_byte", 64'(rx_q[xb]), 64'h41);

    check("rd_en_violations", 64'(rd_viol), 64'd0);
    check("framing_errors", 64'(framing_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
